// File: rtl/aes_cbc_dec_chain_pkg.sv
// Shared definitions for the CBC decipher chaining controller: FSM encodings,
// key-length encodings used by the cipher blocks, and the chaining XOR.
package aes_cbc_dec_chain_pkg;

    localparam int BLOCK_W = 128;

    localparam logic AES_128_BIT_KEY = 1'b0;
    localparam logic AES_256_BIT_KEY = 1'b1;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [2:0] {
        CTRL_IDLE  = 3'd0,
        CTRL_START = 3'd1,
        CTRL_WAIT  = 3'd2,
        CTRL_STORE = 3'd3
    } ctrl_state_t;

    // CBC folds the chaining value into the deciphered block; ECB passes it through.
    function automatic block_t chain_xor(block_t dec, block_t chain, bit chain_en);
        return chain_en ? (dec ^ chain) : dec;
    endfunction

endpackage

// File: rtl/aes_cbc_dec_chain_if.sv
// Ciphertext-in / plaintext-out valid/ready streams of the chaining controller.
interface aes_cbc_dec_chain_if;
    import aes_cbc_dec_chain_pkg::*;

    logic   keylen_in;
    logic   in_valid;
    logic   in_ready;
    block_t in_block;
    logic   out_valid;
    logic   out_ready;
    block_t out_block;

    modport master (
        output keylen_in, in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  keylen_in, in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/aes_cbc_dec_chain.sv
// Sequences one aes_decipher_block operation per accepted ciphertext and applies
// CBC chaining; a one-entry output register lets the next block start early.
module aes_cbc_dec_chain
    import aes_cbc_dec_chain_pkg::*;
#(
    parameter bit CHAIN_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      iv_we,
    input  block_t                    iv,
    aes_cbc_dec_chain_if.slave        stream,
    output logic                      dec_next,
    output logic                      dec_keylen,
    output block_t                    dec_block,
    input  logic                      dec_ready,
    input  block_t                    dec_result,
    output logic                      busy
);

    ctrl_state_t state_q, state_d;
    block_t      cipher_reg;
    block_t      chain_reg;
    block_t      out_block_q;
    logic        out_valid_q;
    logic        keylen_reg;
    logic        accept;
    logic        store;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path infers a latch.
        state_d         = state_q;
        stream.in_ready = 1'b0;
        dec_next        = 1'b0;
        accept          = 1'b0;
        store           = 1'b0;
        unique case (state_q)
            CTRL_IDLE: begin
                stream.in_ready = 1'b1;
                if (stream.in_valid) begin
                    accept  = 1'b1;
                    state_d = CTRL_START;
                end
            end
            CTRL_START: begin
                // The decipher block only samples next while it reports ready.
                if (dec_ready) begin
                    dec_next = 1'b1;
                    state_d  = CTRL_WAIT;
                end
            end
            CTRL_WAIT: begin
                if (dec_ready) state_d = CTRL_STORE;
            end
            CTRL_STORE: begin
                if (!out_valid_q || stream.out_ready) begin
                    store   = 1'b1;
                    state_d = CTRL_IDLE;
                end
            end
            default: state_d = CTRL_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= CTRL_IDLE;
        else          state_q <= state_d;
    end

    // NOTE: the datapath registers are reset too, so a reset drops the in-flight block and the chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cipher_reg  <= '0;
            keylen_reg  <= AES_128_BIT_KEY;
            chain_reg   <= '0;
            out_block_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                cipher_reg <= stream.in_block;
                keylen_reg <= stream.keylen_in;
            end

            // An IV write and an accept in the same IDLE cycle both land; the block sees the new IV.
            if (iv_we && state_q == CTRL_IDLE) chain_reg <= iv;
            else if (store && CHAIN_EN)        chain_reg <= cipher_reg;

            if (store) begin
                out_block_q <= chain_xor(dec_result, chain_reg, CHAIN_EN);
                out_valid_q <= 1'b1;
            end else if (stream.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign stream.out_valid = out_valid_q;
    assign stream.out_block = out_block_q;
    assign dec_block        = cipher_reg;
    assign dec_keylen       = keylen_reg;
    assign busy             = (state_q != CTRL_IDLE);

endmodule

// File: doc/aes_cbc_dec_chain.md
Name: aes_cbc_dec_chain

Overview:
- Controller placed around aes_decipher_block. It accepts ciphertext blocks over a valid/ready stream and issues one `next` per block.
- It waits for the decipher block to complete, then XORs the result with the chaining value to produce CBC plaintext. The chaining value is the IV for the first block, then the previous ciphertext.
- A one-entry output register lets the next block start deciphering while the previous plaintext is still unconsumed.
- Key expansion and round_key supply are outside this block; the key memory is driven by aes_decipher_block's round output.

Parameters:
CHAIN_EN, 1, 1 = CBC (plaintext = D(c) ^ chain); 0 = ECB pass-through (plaintext = D(c), chain register unused).

Ports:
clk  in  1  clock.
reset_n  in  1  reset; asynchronous, active-low.
iv_we  in  1  load chain register from iv; honoured only in IDLE.
iv  in  128  initialisation vector.
keylen_in  in  1  key length for the accepted block, sampled on input handshake.
in_valid  in  1  ciphertext block valid.
in_ready  out  1  block accepted when in_valid & in_ready.
in_block  in  128  ciphertext.
out_valid  out  1  plaintext valid.
out_ready  in  1  plaintext consumed when out_valid & out_ready.
out_block  out  128  plaintext.
dec_next  out  1  one-cycle start pulse to decipher block.
dec_keylen  out  1  latched keylen, stable for the whole operation.
dec_block  out  128  latched ciphertext, driven from cipher_reg.
dec_ready  in  1  decipher block ready.
dec_result  in  128  decipher block new_block.
busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all registers cleared. This includes the FSM (IDLE), cipher_reg, chain_reg, out_block, out_valid and keylen_reg.
- Reset outputs: in_ready=1, dec_next=0, busy=0.
- Reset mid-operation drops any in-flight block and pending output; the bench resets the decipher block together with this block.
- FSM states: IDLE, START, WAIT, STORE.
- IDLE:
  - in_ready=1.
  - On in_valid: cipher_reg<=in_block, keylen_reg<=keylen_in, go to START.
- START:
  - dec_next=1 for exactly this cycle; go to WAIT.
  - Requires dec_ready=1 here; if dec_ready=0, stay in START with dec_next=0 until it is 1.
- WAIT:
  - The decipher block drops ready on the edge that samples next, so dec_ready is 0 on the first WAIT cycle.
  - Remain until dec_ready=1, then go to STORE. No timeout.
- STORE:
  - If out_valid=0, or out_ready=1 in this cycle:
    - out_block <= dec_result ^ chain_reg (CHAIN_EN=1) or dec_result (CHAIN_EN=0).
    - out_valid<=1.
    - chain_reg <= cipher_reg when CHAIN_EN=1.
    - Go to IDLE.
  - Otherwise stall in STORE. dec_result stays stable because the decipher block is idle.
- Output register:
  - out_valid clears on out_ready handshake, unless STORE writes in the same cycle, in which case it stays 1 with the new data.
  - Consecutive plaintexts are emitted in input order with none lost.
- in_ready=0 in START, WAIT and STORE. At most one block is in flight and one is buffered.
- iv_we in IDLE sets chain_reg<=iv.
  - Simultaneous iv_we and in_valid in IDLE: both take effect, and the accepted block uses the new IV.
  - iv_we outside IDLE is ignored.
- Latency, input handshake to dec_next: 1 cycle.
- Latency, dec_ready rise to out_valid: 2 cycles (WAIT→STORE, STORE writes) when the output register is free.
- dec_block and dec_keylen are held constant from accept until the return to IDLE.
- Widths: all datapath 128-bit XOR, no arithmetic.

Decomposition:
- Shared package/constant include: FSM state encodings (3-bit CTRL_IDLE/START/WAIT/STORE) and AES_128_BIT_KEY/AES_256_BIT_KEY key-length encodings, shared with the cipher blocks.
- No sub-module. The one-entry output register is simple enough to stay inline.

Test Plan:
1. ECB reference (decipher block + key memory in bench). AES-128 key 000102030405060708090a0b0c0d0e0f, IV=0, in 69c4e0d86a7b0430d8cdb78070b4c55a → out 00112233445566778899aabbccddeeff, single dec_next pulse.
2. CBC two blocks (SP800-38A F.2.2). Key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102…0f.
   - In 7649abac8119b246cee98e9b12e9197d → out 6bc1bee22e409f96e93d7e117393172a.
   - Then in 5086cb9b507219ee95db113a917678b2 → out ae2d8a571e03ac9c9eb76fac45af8e51.
3. Output backpressure. Hold out_ready=0 while both blocks of test 2 are sent.
   - First plaintext held; second block stalls in STORE with in_ready=0.
   - Releasing out_ready yields both plaintexts, in order, with no loss.
4. IV/input collision. iv_we with iv=000102…0f and in_valid in the same IDLE cycle → block 1 of test 2 decodes correctly.
   - iv_we during WAIT is ignored; block 2 is still correct.
5. Reset mid-WAIT. Assert reset_n=0 during WAIT → out_valid=0, in_ready=1, busy=0, chain_reg=0 immediately.
   - A following test-1 vector decodes correctly.
6. AES-256 with keylen_in=1. FIPS-197 C.3 key 000102…1f, in 8ea2b7ca516745bfeafc49904b496089, IV=0 → out 00112233445566778899aabbccddeeff; dec_keylen=1 throughout.
